// File: rtl/hkspi_responder_pkg.sv
// Shared definitions for the housekeeping SPI responder: FSM states,
// command-byte field positions and the default register address width.
package hkspi_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W         = 8;

  localparam int CMD_WR      = 7;
  localparam int CMD_RD      = 6;
  localparam int CMD_CNT_LSB = 3;
  localparam int CMD_CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/hkspi_responder_if.sv
// Pad-side SPI wires plus the housekeeping register-file strobe bus.
// slave = responder side, master = host pads and register file.
interface hkspi_responder_if
  import hkspi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);
  logic              sck;
  logic              csb;
  logic              sdi;
  logic              sdo;
  logic              sdo_enb;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;

  modport slave (
    input  sck, csb, sdi, reg_rdata,
    output sdo, sdo_enb, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output sck, csb, sdi, reg_rdata,
    input  sdo, sdo_enb, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/hkspi_responder_sync.sv
// Two-flop synchronizers for the SPI pad inputs and SCK edge detection
// from a third delayed flop. CSB resets low so a held-low CSB never looks like a fresh select.
module hkspi_sync (
  input  logic clock,
  input  logic resetb,
  input  logic sck_i,
  input  logic csb_i,
  input  logic sdi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_s_o,
  output logic sdi_s_o
);

  logic [2:0] sck_q;
  logic [1:0] csb_q;
  logic [1:0] sdi_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_q <= 3'b000;
      csb_q <= 2'b00;
      sdi_q <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      csb_q <= {csb_q[0], csb_i};
      sdi_q <= {sdi_q[0], sdi_i};
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign csb_s_o    = csb_q[1];
  assign sdi_s_o    = sdi_q[1];

endmodule

// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder: decodes command/address/data bytes into
// register strobes. Optional HKSPI_FIXED_COUNT_EN limits data bytes per command.
module hkspi_responder
  import hkspi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input logic               clock,
  input logic               resetb,
  hkspi_responder_if.slave  bus
);

  logic sck_rise, sck_fall, csb_s, sdi_s;

  hkspi_sync u_sync (
    .clock      (clock),
    .resetb     (resetb),
    .sck_i      (bus.sck),
    .csb_i      (bus.csb),
    .sdi_i      (bus.sdi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .csb_s_o    (csb_s),
    .sdi_s_o    (sdi_s)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              load_q, load_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              armed_q, armed_d;
`ifdef HKSPI_FIXED_COUNT_EN
  logic [CMD_CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
`endif

  logic [DATA_W-1:0] byte_in;
  logic              byte_done;
  logic              rd_active;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      cmd_wr_q   <= 1'b0;
      cmd_rd_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      load_q     <= 1'b0;
      out_q      <= '0;
      armed_q    <= 1'b0;
`ifdef HKSPI_FIXED_COUNT_EN
      cnt_q      <= '0;
      byte_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      load_q     <= load_d;
      out_q      <= out_d;
      armed_q    <= armed_d;
`ifdef HKSPI_FIXED_COUNT_EN
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    cmd_wr_d  = cmd_wr_q;
    cmd_rd_d  = cmd_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    load_d    = re_q;
    out_d     = out_q;
    armed_d   = armed_q | csb_s;
`ifdef HKSPI_FIXED_COUNT_EN
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
`endif
    byte_in   = {shift_q, sdi_s};
    byte_done = sck_rise && (bit_cnt_q == 3'd7);

    // Output shifter: the fall right after a byte boundary only presents the freshly loaded MSB.
    if (load_q) begin
      out_d = bus.reg_rdata;
    end else if (sck_fall && (state_q == ST_DATA) && (bit_cnt_q != 3'd0)) begin
      out_d = {out_q[DATA_W-2:0], 1'b0};
    end

    // Second half of a write: bump the address, then read-ahead for read/write commands.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
      if (cmd_rd_q && (state_q == ST_DATA)) re_d = 1'b1;
    end

    if ((state_q != ST_IDLE) && csb_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      if (sck_rise && (state_q != ST_IDLE) && (state_q != ST_IGNORE)) begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      unique case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
          if (!csb_s && armed_q) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (byte_done) begin
            cmd_wr_d = byte_in[CMD_WR];
            cmd_rd_d = byte_in[CMD_RD];
`ifdef HKSPI_FIXED_COUNT_EN
            cnt_d      = byte_in[CMD_CNT_LSB +: CMD_CNT_W];
            byte_cnt_d = '0;
`endif
            state_d = (byte_in[CMD_WR] || byte_in[CMD_RD]) ? ST_ADDR : ST_IGNORE;
          end
        end
        ST_ADDR: begin
          if (byte_done) begin
            addr_d  = ADDR_W'(byte_in);
            re_d    = cmd_rd_q;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            if (cmd_wr_q) begin
              we_d    = 1'b1;
              wdata_d = byte_in;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              re_d   = 1'b1;
            end
`ifdef HKSPI_FIXED_COUNT_EN
            byte_cnt_d = byte_cnt_q + 3'd1;
            if ((cnt_q != '0) && (byte_cnt_d == cnt_q)) begin
              state_d = ST_IGNORE;
              re_d    = 1'b0;
            end
`endif
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rd_active     = (state_q == ST_DATA) && cmd_rd_q;
  assign bus.sdo       = rd_active ? out_q[DATA_W-1] : 1'b0;
  assign bus.sdo_enb   = ~rd_active;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
